// File: rtl/mul_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter_if
// Bundles the requester-side and multiplier-side signals of the shared
// multiplier arbiter.
//   slave  modport : the arbiter itself (consumes req/operands/mul results,
//                    drives grants, responses and the multiplier controls)
//   master modport : the environment (requesting clients plus the
//                    multiplier instance)
// Signals:
//   req[N_REQ]          level request per client, held until own resp_valid
//   a_i/b_i[N_REQ*DW]   packed operands, slice k belongs to client k
//   gnt[N_REQ]          one-hot current owner
//   resp_valid[N_REQ]   one-hot single-cycle response strobe
//   resp_data[2*DW]     product (0 on timeout), qualified by resp_valid
//   resp_err            timeout flag, qualified by resp_valid
//   busy                arbiter not idle
//   mul_start           single-cycle start pulse to the multiplier
//   mul_multiplicand    operand A to the multiplier
//   mul_multipliers     operand B to the multiplier
//   mul_ready           multiplier done (rising edge marks completion)
//   mul_product         multiplier result
// ---------------------------------------------------------------------------
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] a_i;
  logic [N_REQ*DW-1:0] b_i;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    resp_valid;
  logic [2*DW-1:0]     resp_data;
  logic                resp_err;
  logic                busy;
  logic                mul_start;
  logic [DW-1:0]       mul_multiplicand;
  logic [DW-1:0]       mul_multipliers;
  logic                mul_ready;
  logic [2*DW-1:0]     mul_product;

  modport slave (
    input  req, a_i, b_i, mul_ready, mul_product,
    output gnt, resp_valid, resp_data, resp_err, busy,
           mul_start, mul_multiplicand, mul_multipliers
  );

  modport master (
    output req, a_i, b_i, mul_ready, mul_product,
    input  gnt, resp_valid, resp_data, resp_err, busy,
           mul_start, mul_multiplicand, mul_multipliers
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
// Shares one sequential multiplier between N_REQ clients. A round-robin
// search picks a requester, its operands are latched and presented to the
// multiplier, a start pulse is issued, and the product is returned on the
// winner's resp_valid strobe. A watchdog ends the wait after TIMEOUT cycles
// and returns resp_err=1 with a zero product.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset (drops any in-flight operation)
//   bus    mul_share_arbiter_if.slave (requester and multiplier signals)
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mul_share_arbiter_if.slave   bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_win;
  logic [CW-1:0] r_cnt;
  logic          r_ready_q;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic          w_done;

  // Index idx+step wrapped modulo N_REQ (step < N_REQ).
  function automatic logic [IW-1:0] f_wrap_add(input logic [IW-1:0] idx, input int step);
    int v_sum;
    v_sum = int'(idx) + step;
    if (v_sum >= N_REQ) begin
      v_sum = v_sum - N_REQ;
    end else begin
      v_sum = v_sum;
    end
    return IW'(v_sum);
  endfunction

  function automatic logic [N_REQ-1:0] f_onehot(input logic [IW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Completion is the rising edge of mul_ready, so a ready level left over
  // from an earlier operation cannot complete the current one.
  assign w_done = bus.mul_ready & ~r_ready_q;

  // Round-robin search: first set request at ptr, ptr+1, ... wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = {IW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && bus.req[f_wrap_add(r_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = f_wrap_add(r_ptr, i);
      end else begin
        w_found = w_found;
        w_win   = w_win;
      end
    end
  end

  // Arbitration FSM; every output is registered and aligned with the state
  // it belongs to (mul_start high during ISSUE, resp_valid high during RESP).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state              <= ST_IDLE;
      r_ptr                <= {IW{1'b0}};
      r_win                <= {IW{1'b0}};
      r_cnt                <= {CW{1'b0}};
      r_ready_q            <= 1'b0;
      bus.gnt              <= {N_REQ{1'b0}};
      bus.resp_valid       <= {N_REQ{1'b0}};
      bus.resp_data        <= {(2*DW){1'b0}};
      bus.resp_err         <= 1'b0;
      bus.busy             <= 1'b0;
      bus.mul_start        <= 1'b0;
      bus.mul_multiplicand <= {DW{1'b0}};
      bus.mul_multipliers  <= {DW{1'b0}};
    end else begin
      r_ready_q <= bus.mul_ready;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_win                <= w_win;
            bus.mul_multiplicand <= bus.a_i[w_win*DW +: DW];
            bus.mul_multipliers  <= bus.b_i[w_win*DW +: DW];
            bus.gnt              <= f_onehot(w_win);
            bus.mul_start        <= 1'b1;
            bus.busy             <= 1'b1;
            r_cnt                <= {CW{1'b0}};
            r_state              <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          bus.mul_start <= 1'b0;
          r_cnt         <= {CW{1'b0}};
          r_state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is tested first so it wins over the watchdog limit.
          if (w_done) begin
            bus.resp_data  <= bus.mul_product;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= f_onehot(r_win);
            r_state        <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            bus.resp_data  <= {(2*DW){1'b0}};
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= f_onehot(r_win);
            r_state        <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          bus.resp_valid <= {N_REQ{1'b0}};
          bus.gnt        <= {N_REQ{1'b0}};
          bus.busy       <= 1'b0;
          r_ptr          <= f_wrap_add(r_win, 1);
          r_state        <= ST_IDLE;
        end
        default: begin
          bus.resp_valid <= {N_REQ{1'b0}};
          bus.gnt        <= {N_REQ{1'b0}};
          bus.busy       <= 1'b0;
          bus.mul_start  <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one sequential multiplier (start/ready handshake, DW x DW -> 2*DW product) between N_REQ requesters. Round-robin arbitration selects a requester, latches its operands, pulses the multiplier start, waits for ready, and returns the product to the winner. A watchdog flags a multiplier that never reports ready. Sits between client blocks and the single multiplier instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 4, operand width; product width is 2*DW
TIMEOUT, 64, max cycles in WAIT before error (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request, level; held until own resp_valid
a_i  input  N_REQ*DW  packed multiplicands, slice k = requester k
b_i  input  N_REQ*DW  packed multipliers, slice k = requester k
gnt  output  N_REQ  one-hot owner of the multiplier
resp_valid  output  N_REQ  one-hot, one-cycle response strobe
resp_data  output  2*DW  product, valid with resp_valid
resp_err  output  1  timeout flag, valid with resp_valid
busy  output  1  high when state != IDLE
mul_start  output  1  one-cycle start pulse to multiplier
mul_multiplicand  output  DW  operand A to multiplier
mul_multipliers  output  DW  operand B to multiplier
mul_ready  input  1  multiplier done/ready
mul_product  input  2*DW  multiplier result

Behaviour:
- Reset (async, rst=1): state IDLE; gnt, resp_valid, resp_data, resp_err, busy, mul_start, mul_multiplicand, mul_multipliers = 0; rr pointer = 0; timeout counter = 0; ready_q = 0. In-flight op discarded, no response issued.
- ready_q registers mul_ready every cycle; completion = mul_ready & ~ready_q (rising edge). A ready already high at start is therefore ignored until it drops and rises again.
- IDLE: if any req bit set, winner = first set bit searching ptr, ptr+1, ... wrapping mod N_REQ. Latch winner index, a_i/b_i slices into mul_multiplicand/mul_multipliers; gnt = onehot(winner); -> ISSUE. No req: stay.
- ISSUE (1 cycle): mul_start=1; counter cleared; -> WAIT.
- WAIT: mul_start=0; operands and gnt held stable. Completion: resp_data <= mul_product, resp_err <= 0, -> RESP. Otherwise counter++; when counter == TIMEOUT-1 without completion: resp_data <= 0, resp_err <= 1, -> RESP. Completion on the same cycle as the limit wins (no error).
- RESP (1 cycle): resp_valid = onehot(winner), resp_data/resp_err presented; ptr <= (winner+1) mod N_REQ; gnt cleared on exit; -> IDLE.
- resp_data/resp_err hold their value until the next RESP capture; resp_valid is the only qualifier.
- req changes after latching in IDLE are ignored for the current op; withdrawn requester still receives its response.
- Operand changes on a_i/b_i after latch have no effect.
- Minimum op time: 3 cycles + multiplier latency; arbiter re-evaluates req in IDLE the cycle after RESP (a requester holding req will not be re-granted ahead of others pending, due to pointer rotation).
- busy = (state != IDLE).

Test Plan:
- Single requester: req=4'b0001, a0=4'hB, b0=4'hB, multiplier model ready after 8 cycles -> gnt=0001, one mul_start pulse, resp_valid=0001 with resp_data=8'h79, resp_err=0.
- Round-robin: req=4'b1111 held, a_k=k+1, b_k=4'h3 -> grants in order 0,1,2,3,0; resp_data 8'h03,8'h06,8'h09,8'h0C; each resp_valid one-hot to matching requester.
- Pointer wrap: after serving requester 3, req=4'b1001 -> requester 0 served before 3 again.
- Timeout: model never raises ready, TIMEOUT=64 -> resp_valid after exactly 64 WAIT cycles, resp_err=1, resp_data=0, state back to IDLE.
- Stale ready: mul_ready held 1 from before ISSUE, falls 2 cycles later, rises at cycle 6 -> capture only at the cycle-6 rising edge.
- Reset mid-op: assert rst during WAIT -> all outputs 0 immediately (async), no resp_valid; after release, pending req=0010 served normally with ptr starting at 0.
